// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - 8x8 sprite pixel-write master for the 160x120 frame buffer
module sprite_plotter #(
    parameter logic [63:0] SPRITE0_MASK = 64'h18183C7EFF3C1818,
    parameter logic [63:0] SPRITE1_MASK = 64'h00663CFF7E3C1800,
    parameter logic [23:0] BG_COLOUR    = 24'h000000,
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    input  logic        sprite_sel,
    input  logic [23:0] colour_in,
    input  logic        erase,
    output logic        busy,
    output logic        done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [23:0] colour,
    output logic        plot
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    state_t      state;
    logic [7:0]  org_x;
    logic [6:0]  org_y;
    logic        sel;
    logic [23:0] fg;
    logic        ers;
    logic [2:0]  col;
    logic [2:0]  row;

    logic [8:0]  sum_x;
    logic [7:0]  sum_y;
    logic [63:0] mask;
    logic        bit_set;

    // One extra bit on each sum so an origin near the edge clips instead of wrapping
    assign sum_x   = {1'b0, org_x} + {6'd0, col};
    assign sum_y   = {1'b0, org_y} + {5'd0, row};
    assign mask    = sel ? SPRITE1_MASK : SPRITE0_MASK;
    assign bit_set = mask[{row, col}];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            col    <= '0;
            row    <= '0;
            org_x  <= '0;
            org_y  <= '0;
            sel    <= 1'b0;
            fg     <= '0;
            ers    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        org_x <= x0;
                        org_y <= y0;
                        sel   <= sprite_sel;
                        fg    <= colour_in;
                        ers   <= erase;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    x      <= sum_x[7:0];
                    y      <= sum_y[6:0];
                    colour <= ers ? BG_COLOUR : fg;
                    plot   <= bit_set && (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
                    col    <= col + 3'd1;
                    if (col == 3'd7) begin
                        row <= row + 3'd1;
                    end
                    // busy drops with the last slot so it never overlaps done
                    if (col == 3'd7 && row == 3'd7) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    plot  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
